fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Front-end fetch stage of the pipeline. Owns the PC, issues requests to the synchronous instruction memory,
//   buffers returned words with their PC in a small prefetch FIFO, and hands them to the F/D pipe register
//   with a valid/ready handshake. Takes branch/jump redirects from the CPU and counts delivered instructions.
// PARAMETERS
//   ADDR_W     32   PC / imem address width
//   DATA_W     32   instruction width
//   FIFO_DEPTH 4    prefetch entries (power of 2, >=2)
//   PC_INC     4    PC increment per sequential fetch
//   RESET_PC   0    PC loaded on reset
// PORTS
//   clk             in   1       clock
//   rst             in   1       synchronous reset, active-high
//   imem_req        out  1       read request to instruction memory
//   imem_addr       out  ADDR_W  request address (= PC register)
//   imem_rdata      in   DATA_W  read data, valid exactly 1 cycle after imem_req
//   redirect_valid  in   1       CPU redirect (taken branch/jump)
//   redirect_pc     in   ADDR_W  redirect target
//   dec_ready       in   1       F/D register can accept this cycle
//   fd_valid        out  1       fd_instr/fd_pc valid
//   fd_instr        out  DATA_W  instruction at FIFO head
//   fd_pc           out  ADDR_W  PC of fd_instr
//   fetch_count     out  32      instructions delivered (perf counter)
// BEHAVIOUR
//   - Reset (sync, active-high): pc=RESET_PC, FIFO empty, inflight=0, fetch_count=0; imem_req=0, fd_valid=0 during rst.
//   - pop  = fd_valid & dec_ready. fd_valid = !fifo_empty & !redirect_valid.
//   - Issue: imem_req = !rst & !redirect_valid & (fifo_count + inflight - pop) < FIFO_DEPTH.
//     On issue: inflight<=1, inflight_pc<=pc, pc<=pc+PC_INC (mod 2^ADDR_W). No issue -> inflight<=0, pc holds.
//   - Return: if inflight & !redirect_valid, push {inflight_pc, imem_rdata} into FIFO next edge.
//     Push and pop same cycle allowed at any occupancy; count never exceeds FIFO_DEPTH, never underflows.
//   - Latency: req at cycle 0 -> push end of cycle 1 -> fd_valid in cycle 2 (3-cycle fetch-to-decode).
//   - Redirect (cycle N): FIFO flushed, arriving imem_rdata discarded, inflight<=0, pc<=redirect_pc, no req,
//     no pop, no count. N+1 req redirect_pc; N+3 fd_valid with fd_pc=redirect_pc.
//   - Redirect wins over simultaneous pop/push/issue. Back-to-back redirects: last one wins.
//   - fetch_count += 1 per pop, wraps mod 2^32.
//   - fd_instr/fd_pc are stable while fd_valid & !dec_ready (no redirect).
//   - rst mid-operation drops all buffered and in-flight state at the next edge.
// STRUCTURE
//   - fetch_pkg: typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] instr;}, RESET_PC, PC_INC.
//   - Sub-module fetch_fifo: sync FIFO of fetch_entry_t with push, pop, flush, count, empty, full;
//     flush has priority over push/pop. PC, inflight tracking, credit check and counter live in fetch_unit.
// TESTING
//   1. Release rst, dec_ready=1, imem model rdata=addr^0xA5A5A5A5 -> fd_pc 0,4,8 in cycles 2,3,4; fetch_count=3 after cycle 4.
//   2. dec_ready=0 for 10 cycles -> FIFO holds 4 entries, imem_req low; set dec_ready=1 -> fd_pc 0,4,8,12,16 in order, no gaps.
//   3. Redirect to 0x100 with 3 entries buffered + 1 in flight -> fd_valid=0 that cycle, next fd_pc=0x100 at N+3, no stale PC.
//   4. Redirect in same cycle as fd_valid&dec_ready -> fetch_count unchanged, head entry not delivered.
//   5. rst high for 1 cycle mid-stream -> next cycle fd_valid=0, fetch_count=0; after release first fd_pc=0.
//   6. Redirect to 0xFFFFFFFC -> fd_pc sequence 0xFFFFFFFC then 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch front end.
//   fetch_entry_t : one prefetch slot, instruction word tagged with its PC
//   RESET_PC      : default PC loaded on reset
//   PC_INC        : default PC step per sequential fetch
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 32;
   localparam int unsigned FETCH_DATA_W = 32;

   localparam logic [FETCH_ADDR_W-1:0] RESET_PC = '0;
   localparam int unsigned             PC_INC   = 4;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO.
//   clk, rst : clock, synchronous active-high reset
//   flush    : discard all entries; overrides push and pop
//   push     : write wdata (ignored when full unless popping in the same cycle)
//   pop      : retire head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry (valid when !empty)
//   count    : current occupancy, 0..DEPTH
//   empty    : count == 0
//   full     : count == DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type         entry_t = fetch_entry_t,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  entry_t                   wdata,
   output entry_t                   rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, issues imem reads, buffers returned words
// with their PC in a prefetch FIFO and presents them to the F/D register.
//   clk, rst        : clock, synchronous active-high reset
//   imem_req        : read request to instruction memory
//   imem_addr       : request address (the PC register)
//   imem_rdata      : read data, returned one cycle after imem_req
//   redirect_valid  : taken branch/jump from the CPU
//   redirect_pc     : redirect target
//   dec_ready       : F/D register can accept this cycle
//   fd_valid        : fd_instr/fd_pc valid
//   fd_instr, fd_pc : FIFO head entry
//   fetch_count     : instructions delivered, wraps mod 2^32
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned              ADDR_W     = 32,
   parameter int unsigned              DATA_W     = 32,
   parameter int unsigned              FIFO_DEPTH = 4,
   parameter int unsigned              PC_INC     = fetch_pkg::PC_INC,
   parameter logic [ADDR_W-1:0]        RESET_PC   = ADDR_W'(fetch_pkg::RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              dec_ready,
   output logic              fd_valid,
   output logic [DATA_W-1:0] fd_instr,
   output logic [ADDR_W-1:0] fd_pc,
   output logic [31:0]       fetch_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } slot_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_push;
   logic              pop;
   logic [CNT_W:0]    occupancy;
   slot_t             push_entry;
   slot_t             head;

   assign fd_valid  = ~fifo_empty & ~redirect_valid & ~rst;
   assign pop       = fd_valid & dec_ready;
   assign fifo_push = inflight & ~redirect_valid & (~fifo_full | pop);
   assign imem_addr = pc;
   assign fd_instr  = head.instr;
   assign fd_pc     = head.pc;

   assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

   // Credit check: a word already in flight will claim a slot, a pop this cycle frees one.
   assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
   assign imem_req  = ~rst & ~redirect_valid &
                      (occupancy < (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop));

   fetch_fifo #(
      .entry_t (slot_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (fifo_push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= pc;
            pc          <= pc + ADDR_W'(PC_INC);
         end
         if (pop) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synchronous imem model returning
// addr ^ MAGIC, expected PCs queued per scenario and compared on delivery.
module tb_fetch_unit;

   localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        fd_valid;
   logic [31:0] fd_instr;
   logic [31:0] fd_pc;
   logic [31:0] fetch_count;

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   fetch_unit #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .FIFO_DEPTH (4),
      .PC_INC     (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .fd_valid       (fd_valid),
      .fd_instr       (fd_instr),
      .fd_pc          (fd_pc),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: data only meaningful the cycle after a request.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? (imem_addr ^ MAGIC) : 'x;
   end

   // Leaves the bench at a negedge with rst held; the next negedge is cycle 0 once rst drops.
   task automatic apply_reset(input logic rdy);
      @(negedge clk);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = rdy;
      @(negedge clk);
      exp_q.delete();
   endtask

   task automatic test_reset();
      apply_reset(1'b1);
      #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++; $display("FAIL reset_req: imem_req=%b required 0", imem_req);
      end
      n_checks++;
      if (fd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: fd_valid=%b required 0", fd_valid);
      end
      n_checks++;
      if (fetch_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_count: fetch_count=%0d required 0", fetch_count);
      end
   endtask

   task automatic test_basic();
      apply_reset(1'b1);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fd_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_c0: req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, fd_valid);
      end
      @(negedge clk); #1;
      n_checks++;
      if (fd_valid !== 1'b0 || imem_addr !== 32'h4) begin
         n_fail++; $display("FAIL basic_c1: valid=%b addr=%h required 0/4", fd_valid, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL basic_deliver: valid=%b pc=%h instr=%h required pc=%h instr=%h",
                               fd_valid, fd_pc, fd_instr, exp_pc, exp_pc ^ MAGIC);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (fetch_count !== 32'd3) begin
         n_fail++; $display("FAIL basic_count: fetch_count=%0d required 3", fetch_count);
      end
   endtask

   task automatic test_stall();
      apply_reset(1'b0);
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
      @(negedge clk); rst = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk); #1;
         if (c >= 6) begin
            n_checks++;
            if (imem_req !== 1'b0 || fd_valid !== 1'b1 || fd_pc !== 32'h0 || fd_instr !== MAGIC) begin
               n_fail++; $display("FAIL stall_hold: req=%b valid=%b pc=%h instr=%h required 0/1/0/%h",
                                  imem_req, fd_valid, fd_pc, fd_instr, MAGIC);
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); dec_ready = 1'b1; #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL stall_drain: valid=%b pc=%h instr=%h required pc=%h", fd_valid, fd_pc, fd_instr, exp_pc);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (fetch_count !== 32'd5) begin
         n_fail++; $display("FAIL stall_count: fetch_count=%0d required 5", fetch_count);
      end
   endtask

   task automatic test_redirect();
      apply_reset(1'b0);
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      n_checks++;
      if (fd_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL redir_n: valid=%b req=%b required 0/0", fd_valid, imem_req);
      end
      @(negedge clk); redirect_valid = 1'b0; dec_ready = 1'b1; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fd_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_n1: req=%b addr=%h valid=%b required 1/100/0", imem_req, imem_addr, fd_valid);
      end
      @(negedge clk); #1;
      n_checks++;
      if (fd_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_n2: valid=%b pc=%h required valid 0", fd_valid, fd_pc);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL redir_deliver: valid=%b pc=%h instr=%h required pc=%h", fd_valid, fd_pc, fd_instr, exp_pc);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (fetch_count !== 32'd3) begin
         n_fail++; $display("FAIL redir_count: fetch_count=%0d required 3", fetch_count);
      end
   endtask

   task automatic test_redirect_pop();
      apply_reset(1'b1);
      exp_q.push_back(32'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (fd_valid !== 1'b1 || fd_pc !== exp_pc) begin
         n_fail++; $display("FAIL rpop_first: valid=%b pc=%h required pc=%h", fd_valid, fd_pc, exp_pc);
      end
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      n_checks++;
      if (fd_valid !== 1'b0 || fetch_count !== 32'd1) begin
         n_fail++; $display("FAIL rpop_n: valid=%b count=%0d required 0/1", fd_valid, fetch_count);
      end
      @(negedge clk); redirect_valid = 1'b0; #1;
      n_checks++;
      if (fetch_count !== 32'd1 || fd_valid !== 1'b0) begin
         n_fail++; $display("FAIL rpop_nocount: count=%0d valid=%b required 1/0", fetch_count, fd_valid);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL rpop_deliver: valid=%b pc=%h required pc=%h", fd_valid, fd_pc, exp_pc);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (fetch_count !== 32'd3) begin
         n_fail++; $display("FAIL rpop_count: fetch_count=%0d required 3", fetch_count);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset(1'b1);
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
      @(negedge clk); rst = 1'b1; #1;
      n_checks++;
      if (fd_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL rmid_during: valid=%b req=%b required 0/0", fd_valid, imem_req);
      end
      @(negedge clk); rst = 1'b0; #1;
      exp_q.push_back(32'h0);
      n_checks++;
      if (fd_valid !== 1'b0 || fetch_count !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL rmid_after: valid=%b count=%0d req=%b addr=%h required 0/0/1/0",
                            fd_valid, fetch_count, imem_req, imem_addr);
      end
      @(negedge clk);
      @(negedge clk); #1;
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
         n_fail++; $display("FAIL rmid_first: valid=%b pc=%h required pc=%h", fd_valid, fd_pc, exp_pc);
      end
   endtask

   task automatic test_wrap();
      apply_reset(1'b1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      @(negedge clk); redirect_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL wrap_deliver: valid=%b pc=%h instr=%h required pc=%h", fd_valid, fd_pc, fd_instr, exp_pc);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset(1'b1);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h300;
      @(negedge clk); redirect_pc = 32'h400; #1;
      exp_q.push_back(32'h400); exp_q.push_back(32'h404);
      n_checks++;
      if (fd_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_fail++; $display("FAIL b2b_second: valid=%b req=%b required 0/0", fd_valid, imem_req);
      end
      @(negedge clk); redirect_valid = 1'b0; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
         n_fail++; $display("FAIL b2b_req: req=%b addr=%h required 1/400", imem_req, imem_addr);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (fd_valid !== 1'b1 || fd_pc !== exp_pc || fd_instr !== (exp_pc ^ MAGIC)) begin
            n_fail++; $display("FAIL b2b_deliver: valid=%b pc=%h required pc=%h", fd_valid, fd_pc, exp_pc);
         end
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      dec_ready      = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_redirect_pop();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
